// File: rtl/ps2_host.sv
// ps2_host -- PS/2 host port: device-to-host receiver plus host-to-device
// transmitter, one instance per PS/2 connector.
//
// Ports:
//   clk, rst_n                  system clock, async active-low reset
//   ps2_clk_in, ps2_dat_in      PS/2 pad levels (asynchronous)
//   ps2_clk_out, ps2_dat_out    open-drain drive: 0 = pull low, 1 = release
//   dataout, dataout_valid      last good received byte + 1-cycle strobe
//   dataout_error               1-cycle strobe: bad or truncated frame
//   datain, datain_valid        byte to send + request (taken only when idle)
//   tx_busy                     transmitter active
//   tx_done, tx_error           1-cycle strobes: device ACK / NACK or timeout
//
// Optional build macro PS2_AUTO_RESEND_EN: a received frame that fails its
// start/parity/stop check automatically queues a 0xFE (resend) command.
module ps2_host #(
    parameter int CLK_FREQ   = 28000000,
    parameter int CLKWAIT_US = 1,
    parameter int RX_TOUT_US = 150,
    parameter int INHIBIT_US = 120,
    parameter int TX_TOUT_US = 15000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_out,
    output logic       ps2_dat_out,
    output logic [7:0] dataout,
    output logic       dataout_valid,
    output logic       dataout_error,
    input  logic [7:0] datain,
    input  logic       datain_valid,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error
);
    // 64-bit arithmetic: TX_TOUT_US * CLK_FREQ overflows 32 bits.
    localparam longint CLKWAIT_L = longint'(CLKWAIT_US) * longint'(CLK_FREQ) / 64'sd1000000 + 64'sd1;
    localparam longint RX_TOUT_L = longint'(RX_TOUT_US) * longint'(CLK_FREQ) / 64'sd1000000 + 64'sd1;
    localparam longint INHIBIT_L = longint'(INHIBIT_US) * longint'(CLK_FREQ) / 64'sd1000000 + 64'sd1;
    localparam longint TX_TOUT_L = longint'(TX_TOUT_US) * longint'(CLK_FREQ) / 64'sd1000000 + 64'sd1;
    localparam longint MAX_A     = (CLKWAIT_L > RX_TOUT_L) ? CLKWAIT_L : RX_TOUT_L;
    localparam longint MAX_B     = (INHIBIT_L > TX_TOUT_L) ? INHIBIT_L : TX_TOUT_L;
    localparam longint MAX_L     = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int     TW        = $clog2(MAX_L + 64'sd1);

    localparam logic [TW-1:0] CLKWAIT_TICKS = TW'(CLKWAIT_L);
    localparam logic [TW-1:0] RX_TOUT_TICKS = TW'(RX_TOUT_L);
    localparam logic [TW-1:0] INHIBIT_TICKS = TW'(INHIBIT_L);
    localparam logic [TW-1:0] TX_TOUT_TICKS = TW'(TX_TOUT_L);

    typedef enum logic [2:0] {
        S_IDLE, S_INHIBIT, S_START, S_BITS, S_ACK, S_WAITIDLE
    } tx_state_t;

    tx_state_t state;

    // ------------------------------------------------------------------
    // Pad synchronisers and fall detect
    // ------------------------------------------------------------------
    logic [1:0] clk_sync, dat_sync;
    logic       clk_prev, clk_s, dat_s, clk_fall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
            clk_prev <= 1'b1;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk_in};
            dat_sync <= {dat_sync[0], ps2_dat_in};
            clk_prev <= clk_s;
        end
    end

    assign clk_s    = clk_sync[1];
    assign dat_s    = dat_sync[1];
    assign clk_fall = clk_prev & ~clk_s;

    // ------------------------------------------------------------------
    // Transmit request arbitration (auto-resend wins over the user)
    // ------------------------------------------------------------------
    logic       chk_err;    // dataout_error caused by the frame check
    logic       auto_req;
    logic       tx_start;
    logic [7:0] tx_src;

`ifdef PS2_AUTO_RESEND_EN
    logic resend_req;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) resend_req <= 1'b0;
        else        resend_req <= chk_err;
    end
    assign auto_req = resend_req;
`else
    logic unused_chk_err;
    assign unused_chk_err = chk_err;
    assign auto_req       = 1'b0;
`endif

    assign tx_start = (state == S_IDLE) && (datain_valid || auto_req);
    assign tx_src   = auto_req ? 8'hFE : datain;

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    logic [9:0]    rx_sr;      // start, data[7:0], parity; oldest bit at [0]
    logic [3:0]    bit_cnt;
    logic [TW-1:0] rx_tmr;
    logic          rx_run;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_sr         <= '0;
            bit_cnt       <= '0;
            rx_tmr        <= '0;
            rx_run        <= 1'b0;
            dataout       <= '0;
            dataout_valid <= 1'b0;
            dataout_error <= 1'b0;
            chk_err       <= 1'b0;
        end else begin
            dataout_valid <= 1'b0;
            dataout_error <= 1'b0;
            chk_err       <= 1'b0;
            if (tx_start || tx_busy) begin
                // Transmit owns the bus: drop any partial frame silently.
                bit_cnt <= '0;
                rx_run  <= 1'b0;
            end else if (clk_fall) begin
                rx_tmr <= TW'(1);
                rx_run <= 1'b1;
                if (bit_cnt == 4'd10) begin
                    // 11th fall: stop bit is on the line now.
                    bit_cnt <= '0;
                    rx_run  <= 1'b0;
                    if (!rx_sr[0] && (^rx_sr[9:1]) && dat_s) begin
                        dataout       <= rx_sr[8:1];
                        dataout_valid <= 1'b1;
                    end else begin
                        dataout_error <= 1'b1;
                        chk_err       <= 1'b1;
                    end
                end
            end else if (rx_run) begin
                rx_tmr <= rx_tmr + TW'(1);
                if (rx_tmr == CLKWAIT_TICKS && !clk_s && bit_cnt < 4'd10) begin
                    rx_sr   <= {dat_s, rx_sr[9:1]};
                    bit_cnt <= bit_cnt + 4'd1;
                end
                if (rx_tmr == RX_TOUT_TICKS) begin
                    rx_run <= 1'b0;
                    if (bit_cnt != 4'd0) begin
                        dataout_error <= 1'b1;
                        bit_cnt       <= '0;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Transmitter FSM
    // ------------------------------------------------------------------
    logic [7:0]    tx_byte;
    logic          tx_par;
    logic [3:0]    tx_n;       // device clock falls seen in BITS
    logic          tx_wait;    // fall seen, waiting CLKWAIT before acting
    logic          tx_nack;
    logic [TW-1:0] tx_cnt;
    logic [TW-1:0] tx_tout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            ps2_clk_out <= 1'b1;
            ps2_dat_out <= 1'b1;
            tx_busy     <= 1'b0;
            tx_done     <= 1'b0;
            tx_error    <= 1'b0;
            tx_byte     <= '0;
            tx_par      <= 1'b0;
            tx_n        <= '0;
            tx_wait     <= 1'b0;
            tx_nack     <= 1'b0;
            tx_cnt      <= '0;
            tx_tout     <= '0;
        end else begin
            tx_done  <= 1'b0;
            tx_error <= 1'b0;
            if (state == S_BITS || state == S_ACK || state == S_WAITIDLE)
                tx_tout <= tx_tout + TW'(1);

            case (state)
                S_IDLE: begin
                    ps2_clk_out <= 1'b1;
                    ps2_dat_out <= 1'b1;
                    if (tx_start) begin
                        tx_byte     <= tx_src;
                        tx_par      <= ~(^tx_src);
                        tx_nack     <= 1'b0;
                        tx_busy     <= 1'b1;
                        ps2_clk_out <= 1'b0;
                        tx_cnt      <= TW'(1);
                        state       <= S_INHIBIT;
                    end
                end
                S_INHIBIT: begin
                    tx_cnt <= tx_cnt + TW'(1);
                    if (tx_cnt == INHIBIT_TICKS) begin
                        ps2_dat_out <= 1'b0;
                        tx_cnt      <= TW'(1);
                        state       <= S_START;
                    end
                end
                S_START: begin
                    tx_cnt <= tx_cnt + TW'(1);
                    if (tx_cnt == CLKWAIT_TICKS) begin
                        ps2_clk_out <= 1'b1;
                        tx_tout     <= TW'(1);
                        tx_n        <= '0;
                        tx_wait     <= 1'b0;
                        state       <= S_BITS;
                    end
                end
                S_BITS: begin
                    if (clk_fall) begin
                        tx_n    <= tx_n + 4'd1;
                        tx_cnt  <= TW'(1);
                        tx_wait <= 1'b1;
                    end else if (tx_wait) begin
                        tx_cnt <= tx_cnt + TW'(1);
                        if (tx_cnt == CLKWAIT_TICKS) begin
                            tx_wait <= 1'b0;
                            if (tx_n <= 4'd8) begin
                                ps2_dat_out <= tx_byte[3'(tx_n - 4'd1)];
                            end else if (tx_n == 4'd9) begin
                                ps2_dat_out <= tx_par;
                            end else begin
                                ps2_dat_out <= 1'b1;   // stop, line released
                                state       <= S_ACK;
                            end
                        end
                    end
                end
                S_ACK: begin
                    if (clk_fall) begin
                        tx_cnt  <= TW'(1);
                        tx_wait <= 1'b1;
                    end else if (tx_wait) begin
                        tx_cnt <= tx_cnt + TW'(1);
                        if (tx_cnt == CLKWAIT_TICKS) begin
                            tx_wait <= 1'b0;
                            if (dat_s) begin
                                tx_nack  <= 1'b1;
                                tx_error <= 1'b1;
                            end
                            state <= S_WAITIDLE;
                        end
                    end
                end
                S_WAITIDLE: begin
                    if (clk_s && dat_s) begin
                        tx_done <= ~tx_nack;
                        tx_busy <= 1'b0;
                        state   <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase

            // Whole-transfer timeout; a NACK already reported stays the
            // only error for this request.
            if ((state == S_BITS || state == S_ACK || state == S_WAITIDLE) &&
                tx_tout == TX_TOUT_TICKS) begin
                tx_error    <= ~tx_nack;
                tx_done     <= 1'b0;
                ps2_clk_out <= 1'b1;
                ps2_dat_out <= 1'b1;
                tx_busy     <= 1'b0;
                state       <= S_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_ps2_host.sv
`timescale 1ns/1ps
module tb_ps2_host;
    localparam int HALF       = 150;   // device clock half period, in clk cycles
    localparam int TX_TOUT_US = 300;   // 8401 ticks at 28 MHz

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       dev_clk = 1'b1, dev_dat = 1'b1;
    logic       ps2_clk_in, ps2_dat_in, ps2_clk_out, ps2_dat_out;
    logic [7:0] dataout, datain = 8'h00;
    logic       dataout_valid, dataout_error, datain_valid = 1'b0;
    logic       tx_busy, tx_done, tx_error;

    // Open-drain bus: either side can pull low.
    assign ps2_clk_in = ps2_clk_out & dev_clk;
    assign ps2_dat_in = ps2_dat_out & dev_dat;

    ps2_host #(.TX_TOUT_US(TX_TOUT_US)) dut (
        .clk(clk), .rst_n(rst_n),
        .ps2_clk_in(ps2_clk_in), .ps2_dat_in(ps2_dat_in),
        .ps2_clk_out(ps2_clk_out), .ps2_dat_out(ps2_dat_out),
        .dataout(dataout), .dataout_valid(dataout_valid), .dataout_error(dataout_error),
        .datain(datain), .datain_valid(datain_valid),
        .tx_busy(tx_busy), .tx_done(tx_done), .tx_error(tx_error)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    int cyc = 0;
    int last_fall_cyc = 0, last_err_cyc = 0;
    int n_valid = 0, n_err = 0, n_done = 0, n_txerr = 0;
    logic [7:0] exp_q[$];      // bytes the device has sent with a good frame
    logic [7:0] model_last = 8'h00;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic chk_rng(input string name, input longint act, input longint lo, input longint hi);
        checks++;
        if (act < lo || act > hi) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Compare process: every cycle out of reset.
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (dataout_valid) begin
                n_valid++;
                chk("rx_valid_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) model_last = exp_q.pop_front();
            end
            if (dataout_error) begin
                n_err++;
                last_err_cyc = cyc;
            end
            if (tx_done)  n_done++;
            if (tx_error) n_txerr++;
            chk("dataout_hold", dataout, model_last);
            chk("rx_strobe_excl", dataout_valid & dataout_error, 0);
            chk("tx_strobe_excl", tx_done & tx_error, 0);
            if (!tx_busy) chk("idle_lines", {ps2_clk_out, ps2_dat_out}, 2'b11);
        end
    end

    // Device-to-host: nb bits of an 11-bit frame, data changed while clock high.
    task automatic send_bits(input logic [7:0] b, input logic bad_par, input int nb);
        logic [10:0] f;
        f = {1'b1, (~(^b)) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nb; i++) begin
            dev_dat = f[i];
            tick(HALF);
            dev_clk = 1'b0;
            last_fall_cyc = cyc;
            tick(HALF);
            dev_clk = 1'b1;
        end
        tick(HALF);
        dev_dat = 1'b1;
    endtask

    task automatic req(input logic [7:0] b);
        datain = b;
        datain_valid = 1'b1;
        tick(1);
        datain_valid = 1'b0;
    endtask

    // Host-to-device: device clocks 11 pulses, samples on each rise,
    // optionally ACKs on the 11th. bits = {stop, parity, data[7:0]}.
    task automatic dev_tx(input logic ack, output logic [9:0] bits);
        int i;
        bits = '0;
        i = 0;
        while (!(tx_busy && ps2_clk_out && !ps2_dat_out) && i < 5000) begin
            tick(1);
            i++;
        end
        chk("tx_release_seen", i < 5000, 1);
        if (i >= 5000) return;
        chk("tx_start_bit", ps2_dat_in, 0);
        tick(HALF);
        for (int n = 1; n <= 11; n++) begin
            if (n == 11 && ack) dev_dat = 1'b0;
            dev_clk = 1'b0;
            tick(HALF);
            if (n <= 10) bits[n-1] = ps2_dat_in;
            dev_clk = 1'b1;
            tick(HALF);
        end
        dev_dat = 1'b1;
    endtask

    task automatic wait_not_busy(input int lim, output int waited);
        waited = 0;
        while (tx_busy && waited < lim) begin
            tick(1);
            waited++;
        end
        chk("tx_busy_drop", tx_busy, 0);
    endtask

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int w, d0, e0, r0;
        logic [9:0] bits;

        // Reset values
        rst_n = 1'b0;
        tick(4);
        chk("rst_clk_out", ps2_clk_out, 1);
        chk("rst_dat_out", ps2_dat_out, 1);
        chk("rst_dataout", dataout, 8'h00);
        chk("rst_strobes", {dataout_valid, dataout_error, tx_done, tx_error}, 4'b0000);
        chk("rst_busy", tx_busy, 0);
        rst_n = 1'b1;
        tick(4);

        // Good frame 0x1C (parity 0)
        exp_q.push_back(8'h1C);
        send_bits(8'h1C, 1'b0, 11);
        tick(10);
        chk("rx1_valid_cnt", n_valid, 1);
        chk("rx1_err_cnt", n_err, 0);
        chk("rx1_data", dataout, 8'h1C);

        // Same byte, wrong parity
        send_bits(8'h1C, 1'b1, 11);
        tick(10);
        chk("rx2_err_cnt", n_err, 1);
        chk("rx2_valid_cnt", n_valid, 1);
        chk("rx2_data_held", dataout, 8'h1C);
`ifdef PS2_AUTO_RESEND_EN
        dev_tx(1'b1, bits);
        chk("resend_byte", bits[7:0], 8'hFE);
        chk("resend_par", bits[8], 0);
        chk("resend_stop", bits[9], 1);
        wait_not_busy(2000, w);
        tick(3);
        chk("resend_done", n_done, 1);
`endif

        // Truncated frame: 5 bits then silence
        send_bits(8'h5A, 1'b0, 5);
        w = 0;
        while (n_err < 2 && w < 6000) begin
            tick(1);
            w++;
        end
        chk("rxto_err_cnt", n_err, 2);
        // RX_TOUT_TICKS=4201 plus synchroniser / edge-detect latency
        chk_rng("rxto_delay", last_err_cyc - last_fall_cyc, 4201, 4206);
        exp_q.push_back(8'h5A);
        send_bits(8'h5A, 1'b0, 11);
        tick(10);
        chk("rx3_data", dataout, 8'h5A);
        chk("rx3_valid_cnt", n_valid, 2);
        chk("rx3_err_cnt", n_err, 2);

        // Transmit 0xED with ACK
        d0 = n_done; e0 = n_txerr;
        req(8'hED);
        chk("tx1_busy", tx_busy, 1);
        w = 0;
        while (tx_busy && !ps2_clk_out && ps2_dat_out && w < 5000) begin
            w++;
            tick(1);
        end
        chk("tx1_inhibit_len", w, 3361);
        chk("tx1_start_clk_low", {ps2_clk_out, ps2_dat_out}, 2'b00);
        dev_tx(1'b1, bits);
        chk("tx1_byte", bits[7:0], 8'hED);
        chk("tx1_par", bits[8], 1);
        chk("tx1_stop", bits[9], 1);
        wait_not_busy(2000, w);
        tick(3);
        chk("tx1_done_cnt", n_done, d0 + 1);
        chk("tx1_err_cnt", n_txerr, e0);

        // Same request, device NACKs
        d0 = n_done; e0 = n_txerr;
        req(8'hED);
        dev_tx(1'b0, bits);
        chk("tx2_byte", bits[7:0], 8'hED);
        wait_not_busy(2000, w);
        tick(3);
        chk("tx2_err_cnt", n_txerr, e0 + 1);
        chk("tx2_done_cnt", n_done, d0);

        // Device never clocks: whole-transfer timeout
        d0 = n_done; e0 = n_txerr;
        req(8'h55);
        wait_not_busy(20000, w);
        tick(3);
        chk_rng("tx3_tout_len", w, 3361 + 29 + 8401, 3361 + 29 + 8401 + 4);
        chk("tx3_err_cnt", n_txerr, e0 + 1);
        chk("tx3_done_cnt", n_done, d0);
        chk("tx3_lines", {ps2_clk_out, ps2_dat_out}, 2'b11);

        // Half-received frame aborted by a transmit request
        d0 = n_done; r0 = n_err;
        send_bits(8'h33, 1'b0, 5);
        req(8'hF4);
        dev_tx(1'b1, bits);
        chk("tx4_byte", bits[7:0], 8'hF4);
        chk("tx4_par", bits[8], 0);
        wait_not_busy(2000, w);
        tick(4500);
        chk("tx4_done_cnt", n_done, d0 + 1);
        chk("tx4_rx_silent", n_err, r0);

        // Reset in the middle of BITS
        req(8'h00);
        w = 0;
        while (!(tx_busy && ps2_clk_out && !ps2_dat_out) && w < 5000) begin
            tick(1);
            w++;
        end
        tick(HALF);
        for (int n = 0; n < 3; n++) begin
            dev_clk = 1'b0; tick(HALF);
            dev_clk = 1'b1; tick(HALF);
        end
        dev_clk = 1'b0;
        tick(60);
        chk("pre_rst_busy", tx_busy, 1);
        chk("pre_rst_dat", ps2_dat_out, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_lines", {ps2_clk_out, ps2_dat_out}, 2'b11);
        chk("rst_mid_busy", tx_busy, 0);
        dev_clk = 1'b1;
        dev_dat = 1'b1;
        model_last = 8'h00;
        tick(3);
        chk("rst_mid_dataout", dataout, 8'h00);
        rst_n = 1'b1;
        tick(10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
